// File: rtl/btn_input_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : btn_input_ctrl
//  Purpose  : Player-input front end for the battleships board. Synchronizes
//             and debounces the five pushbuttons, turns the direction
//             buttons into a wrapped cursor position with auto-repeat, and
//             turns the centre button into a one-cycle fire pulse.
//  Ports    : clk        - system clock
//             rst_n      - asynchronous active-low reset
//             enable     - game active; low freezes cursor and pulses
//             btnU/D/L/R - raw direction buttons (asynchronous, bouncy)
//             btnC       - raw fire button
//             cursor_x   - current column (0..GRID_SIZE-1)
//             cursor_y   - current row    (0..GRID_SIZE-1)
//             fire_pulse - one-cycle pulse per accepted fire press
//             move_pulse - one-cycle pulse when the cursor moved
//  Revision : 1.0 - initial release
// ============================================================================
module btn_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 15000000,
  parameter int GRID_SIZE       = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnC,
  output logic [3:0] cursor_x,
  output logic [3:0] cursor_y,
  output logic       fire_pulse,
  output logic       move_pulse
);

  // Button lane indices inside the packed vectors below.
  localparam int BTN_U = 0;
  localparam int BTN_D = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_C = 4;

  // One counter width serves every phase of the per-button FSM.
  localparam int CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_DELAY) ?
                           ((DEBOUNCE_CYCLES > REPEAT_RATE) ? DEBOUNCE_CYCLES : REPEAT_RATE) :
                           ((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] DEB_C   = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] RD_C    = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RR_C    = CW'(REPEAT_RATE);

  localparam logic [3:0] GRID_MAX = 4'(GRID_SIZE - 1);

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_PRESS_WAIT   = 3'd1;
  localparam logic [2:0] ST_HELD         = 3'd2;
  localparam logic [2:0] ST_REPEAT       = 3'd3;
  localparam logic [2:0] ST_RELEASE_WAIT = 3'd4;

  logic [4:0] raw;
  logic [4:0] sync1;
  logic [4:0] sync2;
  logic [4:0] step;

  assign raw = {btnC, btnR, btnL, btnD, btnU};

  // Two-flop synchronizer on every raw button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // --------------------------------------------------------------------------
  // Per-button debounce / auto-repeat FSM. step is a registered one-cycle
  // strobe so the cursor/fire registers below update the cycle after it.
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < 5; i++) begin : g_btn
      localparam bit IS_DIR = (i != BTN_C);

      logic [2:0]    state;
      logic [CW-1:0] cnt;
      logic [CW-1:0] cnt_inc;
      logic          was_rep;
      logic          step_q;
      logic          s;

      assign s       = sync2[i];
      assign cnt_inc = cnt + CNT_ONE;
      assign step[i] = step_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state   <= ST_IDLE;
          cnt     <= '0;
          was_rep <= 1'b0;
          step_q  <= 1'b0;
        end else begin
          step_q <= 1'b0;
          case (state)
            ST_IDLE: begin
              if (s) begin
                // The first high sample already counts towards the debounce.
                if (CNT_ONE == DEB_C) begin
                  state   <= ST_HELD;
                  step_q  <= 1'b1;
                  was_rep <= 1'b0;
                  cnt     <= '0;
                end else begin
                  state <= ST_PRESS_WAIT;
                  cnt   <= CNT_ONE;
                end
              end
            end

            ST_PRESS_WAIT: begin
              if (!s) begin
                state <= ST_IDLE;
                cnt   <= '0;
              end else if (cnt_inc == DEB_C) begin
                state   <= ST_HELD;
                step_q  <= 1'b1;
                was_rep <= 1'b0;
                cnt     <= '0;
              end else begin
                cnt <= cnt_inc;
              end
            end

            ST_HELD: begin
              if (!s) begin
                if (CNT_ONE == DEB_C) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
                end else begin
                  state <= ST_RELEASE_WAIT;
                  cnt   <= CNT_ONE;
                end
              end else if (cnt_inc == RD_C) begin
                // Fire never repeats: it simply stays parked in HELD.
                cnt <= '0;
                if (IS_DIR) begin
                  state   <= ST_REPEAT;
                  was_rep <= 1'b1;
                end
              end else begin
                cnt <= cnt_inc;
              end
            end

            ST_REPEAT: begin
              if (!s) begin
                if (CNT_ONE == DEB_C) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
                end else begin
                  state <= ST_RELEASE_WAIT;
                  cnt   <= CNT_ONE;
                end
              end else if (cnt_inc == RR_C) begin
                step_q <= 1'b1;
                cnt    <= '0;
              end else begin
                cnt <= cnt_inc;
              end
            end

            ST_RELEASE_WAIT: begin
              if (s) begin
                // Release bounce: resume the held phase silently.
                state <= was_rep ? ST_REPEAT : ST_HELD;
                cnt   <= '0;
              end else if (cnt_inc == DEB_C) begin
                state <= ST_IDLE;
                cnt   <= '0;
              end else begin
                cnt <= cnt_inc;
              end
            end

            default: begin
              state <= ST_IDLE;
              cnt   <= '0;
            end
          endcase
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Cursor arithmetic. Opposing steps on one axis cancel (XOR); when only one
  // of the pair fires, the R/D step selects increment, otherwise decrement.
  // --------------------------------------------------------------------------
  logic       x_mv;
  logic       y_mv;
  logic [3:0] x_inc;
  logic [3:0] x_dec;
  logic [3:0] y_inc;
  logic [3:0] y_dec;
  logic [3:0] x_next;
  logic [3:0] y_next;

  assign x_mv   = step[BTN_R] ^ step[BTN_L];
  assign y_mv   = step[BTN_D] ^ step[BTN_U];
  assign x_inc  = (cursor_x == GRID_MAX) ? 4'd0 : cursor_x + 4'd1;
  assign x_dec  = (cursor_x == 4'd0) ? GRID_MAX : cursor_x - 4'd1;
  assign y_inc  = (cursor_y == GRID_MAX) ? 4'd0 : cursor_y + 4'd1;
  assign y_dec  = (cursor_y == 4'd0) ? GRID_MAX : cursor_y - 4'd1;
  assign x_next = step[BTN_R] ? x_inc : x_dec;
  assign y_next = step[BTN_D] ? y_inc : y_dec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cursor_x   <= 4'd0;
      cursor_y   <= 4'd0;
      fire_pulse <= 1'b0;
      move_pulse <= 1'b0;
    end else begin
      fire_pulse <= enable & step[BTN_C];
      move_pulse <= enable & (x_mv | y_mv);
      if (enable) begin
        if (x_mv) cursor_x <= x_next;
        if (y_mv) cursor_y <= y_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_btn_input_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_btn_input_ctrl
//  Purpose  : Self-checking bench for btn_input_ctrl: directed table of
//             press/hold records, hand-written latency, bounce and reset
//             sequences, and a randomized run against a schedule-based
//             reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_btn_input_ctrl;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 8;
  localparam int G  = 10;
  localparam int RN = 3000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       btnU, btnD, btnL, btnR, btnC;
  logic [3:0] cursor_x, cursor_y;
  logic       fire_pulse, move_pulse;

  int tests  = 0;
  int failed = 0;

  btn_input_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .GRID_SIZE      (G)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .btnU      (btnU),
    .btnD      (btnD),
    .btnL      (btnL),
    .btnR      (btnR),
    .btnC      (btnC),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .fire_pulse(fire_pulse),
    .move_pulse(move_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Directed record: mask bits are {U, D, L, R, C}.
  typedef struct {
    logic [4:0] mask;
    int         hold;
    logic       en;
    int         ex;
    int         ey;
    int         ef;
    int         em;
  } vec_t;

  vec_t tbl[15];

  // Randomized schedule and the expected cursor-update events derived from it.
  // Lane order: 0=U, 1=D, 2=L, 3=R, 4=C.
  bit raw_s [5][RN+100];
  bit en_s  [RN+100];
  bit ev    [5][RN+100];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_btns(input logic [4:0] m);
    btnU = m[4];
    btnD = m[3];
    btnL = m[2];
    btnR = m[1];
    btnC = m[0];
  endtask

  task automatic run_hold(input logic [4:0] m, input int hold, input int gap,
                          output int fc, output int mc);
    fc = 0;
    mc = 0;
    set_btns(m);
    repeat (hold) begin
      @(posedge clk); #1;
      fc += int'(fire_pulse);
      mc += int'(move_pulse);
    end
    set_btns(5'b0);
    repeat (gap) begin
      @(posedge clk); #1;
      fc += int'(fire_pulse);
      mc += int'(move_pulse);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_btns(5'b0);
    enable = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int fc, mc;
    logic [14:0] pat;

    // Hold lengths: L>=D gives one step; direction repeats at
    // rise+D+2+RD+RR*k while that edge is <= rise+L+2.
    tbl[0]  = '{5'b00001,  2, 1'b1, 1, 0, 0, 0};   // short fire glitch
    tbl[1]  = '{5'b00001, 40, 1'b1, 1, 0, 1, 0};   // long fire, no repeat
    tbl[2]  = '{5'b00010, 60, 1'b1, 6, 0, 0, 5};   // R: 1 step + 4 repeats
    tbl[3]  = '{5'b00010, 32, 1'b1, 8, 0, 0, 2};   // first repeat at boundary
    tbl[4]  = '{5'b00010, 10, 1'b1, 9, 0, 0, 1};
    tbl[5]  = '{5'b00010, 10, 1'b1, 0, 0, 0, 1};   // wrap 9 -> 0
    tbl[6]  = '{5'b10000, 10, 1'b1, 0, 9, 0, 1};   // wrap 0 -> 9 on y
    tbl[7]  = '{5'b00110, 10, 1'b1, 0, 9, 0, 0};   // L+R cancel
    tbl[8]  = '{5'b10010, 10, 1'b1, 1, 8, 0, 1};   // U+R, single move
    tbl[9]  = '{5'b00100, 10, 1'b1, 0, 8, 0, 1};
    tbl[10] = '{5'b00100, 10, 1'b1, 9, 8, 0, 1};   // wrap 0 -> 9 on x
    tbl[11] = '{5'b01000, 10, 1'b0, 9, 8, 0, 0};   // disabled move
    tbl[12] = '{5'b00001, 10, 1'b0, 9, 8, 0, 0};   // disabled fire
    tbl[13] = '{5'b01001, 10, 1'b1, 9, 9, 1, 1};   // fire and move together
    tbl[14] = '{5'b01000, 10, 1'b1, 9, 0, 0, 1};   // wrap 9 -> 0 on y

    rst_n  = 1'b0;
    enable = 1'b1;
    set_btns(5'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_x",    int'(cursor_x),   0);
    check("reset_y",    int'(cursor_y),   0);
    check("reset_fire", int'(fire_pulse), 0);
    check("reset_move", int'(move_pulse), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fire latency: pulse exactly after edge D+3.
    btnC = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      check($sformatf("fire_latency_e%0d", e), int'(fire_pulse), (e == D + 3) ? 1 : 0);
    end
    btnC = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // Bouncy R: 1,0,1,0 then stable 1 from edge 5 -> single move after edge 11.
    pat = 15'b111_1111_1111_0101;
    for (int e = 1; e <= 15; e++) begin
      btnR = pat[e-1];
      @(posedge clk); #1;
      check($sformatf("bounce_move_e%0d", e), int'(move_pulse), (e == 11) ? 1 : 0);
    end
    check("bounce_x", int'(cursor_x), 1);
    btnR = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // Directed table.
    for (int i = 0; i < 15; i++) begin
      enable = tbl[i].en;
      run_hold(tbl[i].mask, tbl[i].hold, 12, fc, mc);
      check($sformatf("tbl%0d_x", i),    int'(cursor_x), tbl[i].ex);
      check($sformatf("tbl%0d_y", i),    int'(cursor_y), tbl[i].ey);
      check($sformatf("tbl%0d_fire", i), fc, tbl[i].ef);
      check($sformatf("tbl%0d_move", i), mc, tbl[i].em);
      enable = 1'b1;
    end

    // Reset mid-repeat: x=9 -> 0 (edge 7) -> 1 (edge 35), then async reset.
    btnR = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("pre_reset_x", int'(cursor_x), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_x",    int'(cursor_x),   0);
    check("async_reset_y",    int'(cursor_y),   0);
    check("async_reset_fire", int'(fire_pulse), 0);
    check("async_reset_move", int'(move_pulse), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk); #1;
      check($sformatf("post_reset_x_e%0d", e), int'(cursor_x), (e >= D + 3) ? 1 : 0);
      check($sformatf("post_reset_move_e%0d", e), int'(move_pulse), (e == D + 3) ? 1 : 0);
    end
    btnR = 1'b0;
    repeat (12) @(posedge clk);

    // Randomized run: build per-button press schedules, then derive the cycle
    // of every expected cursor/fire update from the timing rules directly.
    for (int b = 0; b < 5; b++) begin
      int t;
      t = 1;
      while (1) begin
        int lo, len, u0;
        lo = $urandom_range(12, D + 1);
        t += lo;
        if (t > RN - 80) break;
        if ($urandom_range(1, 0) == 1) len = $urandom_range(D - 1, 1);
        else                           len = $urandom_range(70, D);
        for (int k = 0; k < len; k++) raw_s[b][t+k] = 1'b1;
        if (len >= D) begin
          u0 = t + D + 2;
          ev[b][u0] = 1'b1;
          if (b != 4) begin
            for (int k = 1; u0 + RD + RR * k <= t + len + 2; k++)
              ev[b][u0 + RD + RR * k] = 1'b1;
          end
        end
        t += len;
      end
    end
    for (int n = 0; n < RN + 100; n++) en_s[n] = ($urandom_range(7, 0) != 0);

    do_reset();
    begin
      int ex, ey, dx, dy, ef, em;
      ex = 0;
      ey = 0;
      for (int n = 1; n <= RN + 10; n++) begin
        btnU   = raw_s[0][n];
        btnD   = raw_s[1][n];
        btnL   = raw_s[2][n];
        btnR   = raw_s[3][n];
        btnC   = raw_s[4][n];
        enable = en_s[n];
        @(posedge clk); #1;
        dx = int'(ev[3][n]) - int'(ev[2][n]);
        dy = int'(ev[1][n]) - int'(ev[0][n]);
        ef = 0;
        em = 0;
        if (en_s[n]) begin
          ef = int'(ev[4][n]);
          em = (dx != 0 || dy != 0) ? 1 : 0;
          ex = (ex + dx + G) % G;
          ey = (ey + dy + G) % G;
        end
        check($sformatf("rand_n%0d {x,y,fire,move}", n),
              int'({cursor_x, cursor_y, fire_pulse, move_pulse}),
              (ex << 6) | (ey << 2) | (ef << 1) | em);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
